// File: rtl/prog_loader.sv
// prog_loader: writes a host word stream into instruction memory and sectored data memory; gates core_run.
// Latency: write strobe/address/data are registered and appear one cycle after the word is accepted.
// Backpressure: none, in_ready is always high. Optional LOADER_CHECKSUM_EN adds a trailing checksum word per load.
module prog_loader #(
    parameter int IMEM_AW = 8,
    parameter int DATA_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [3:0]         dmem_sector,
    output logic [3:0]         dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               core_run,
    output logic               busy,
    output logic               err
);

    localparam logic [3:0]         CMD_LOAD_INSTR = 4'd1;
    localparam logic [3:0]         CMD_LOAD_DATA  = 4'd2;
    localparam logic [3:0]         CMD_RUN        = 4'd3;
    localparam logic [3:0]         CMD_HALT       = 4'd4;
    localparam logic [IMEM_AW-1:0] IADDR_ONE      = IMEM_AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IADDR   = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_RUN     = 3'd3
`ifdef LOADER_CHECKSUM_EN
        , ST_CKSUM = 3'd4
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           rem_q, rem_d;
    logic                 is_instr_q, is_instr_d;
    logic [IMEM_AW-1:0]   iaddr_q, iaddr_d;
    logic [3:0]           dsec_q, dsec_d;
    logic [3:0]           daddr_q, daddr_d;
    logic                 err_q, err_d;
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 dmem_we_q, dmem_we_d;
    logic [3:0]           dmem_sector_q, dmem_sector_d;
    logic [3:0]           dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]    dmem_wdata_q, dmem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]    csum_q, csum_d;
`endif

    logic [3:0] hdr_cmd;
    logic [3:0] hdr_sector;
    logic [7:0] hdr_n;

    assign hdr_cmd    = in_data[15:12];
    assign hdr_sector = in_data[11:8];
    assign hdr_n      = in_data[7:0];

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        is_instr_d    = is_instr_q;
        iaddr_d       = iaddr_q;
        dsec_d        = dsec_q;
        daddr_d       = daddr_q;
        err_d         = err_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        dmem_we_d     = 1'b0;
        dmem_sector_d = dmem_sector_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    case (hdr_cmd)
                        CMD_LOAD_INSTR: begin
                            err_d = 1'b0;
                            if (hdr_n != 8'd0) begin
                                rem_d      = hdr_n;
                                is_instr_d = 1'b1;
                                state_d    = ST_IADDR;
                            end
                        end
                        CMD_LOAD_DATA: begin
                            err_d   = 1'b0;
                            dsec_d  = hdr_sector;
                            daddr_d = 4'd0;
                            if (hdr_n != 8'd0) begin
                                rem_d      = hdr_n;
                                is_instr_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                                csum_d     = '0;
`endif
                                state_d    = ST_PAYLOAD;
                            end
                        end
                        CMD_RUN: begin
                            err_d   = 1'b0;
                            state_d = ST_RUN;
                        end
                        CMD_HALT: ;
                        default: err_d = 1'b1;
                    endcase
                end
                ST_IADDR: begin
                    iaddr_d = in_data[IMEM_AW-1:0];
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (is_instr_q) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = iaddr_q;
                        imem_wdata_d = in_data;
                        iaddr_d      = iaddr_q + IADDR_ONE;
                    end else begin
                        dmem_we_d     = 1'b1;
                        dmem_sector_d = dsec_q;
                        dmem_addr_d   = daddr_q;
                        dmem_wdata_d  = in_data;
                        daddr_d       = daddr_q + 4'd1;
                        // crossing the end of a sector rolls into the next one
                        if (daddr_q == 4'd15) begin
                            dsec_d = dsec_q + 4'd1;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data;
`endif
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    if (in_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
`endif
                ST_RUN: begin
                    if (hdr_cmd == CMD_HALT) begin
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            is_instr_q    <= 1'b0;
            iaddr_q       <= '0;
            dsec_q        <= '0;
            daddr_q       <= '0;
            err_q         <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            dmem_we_q     <= 1'b0;
            dmem_sector_q <= '0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            is_instr_q    <= is_instr_d;
            iaddr_q       <= iaddr_d;
            dsec_q        <= dsec_d;
            daddr_q       <= daddr_d;
            err_q         <= err_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            dmem_we_q     <= dmem_we_d;
            dmem_sector_q <= dmem_sector_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign in_ready    = 1'b1;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_sector = dmem_sector_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign core_run    = (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus random command packets; writes checked by a scoreboard monitor.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        dmem_we;
    logic [3:0]  dmem_sector;
    logic [3:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic        core_run;
    logic        busy;
    logic        err;

    prog_loader dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_sector(dmem_sector), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .core_run(core_run), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_i;
        logic [7:0]  ia;
        logic [3:0]  sec;
        logic [3:0]  da;
        logic [15:0] d;
        int          cyc;
    } wr_t;
    wr_t sb[$];

    // reference model flags at packet granularity
    bit m_err;
    bit m_run;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w, input int gap, output int acc);
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clock);
        acc = cyc;
        #1 in_valid = 1'b0;
    endtask

    task automatic push_i(input int a, input logic [15:0] d, input int acc);
        wr_t e;
        e.is_i = 1'b1; e.ia = 8'(a % 256); e.sec = 4'd0; e.da = 4'd0; e.d = d; e.cyc = acc + 1;
        sb.push_back(e);
    endtask

    task automatic push_d(input int lin, input logic [15:0] d, input int acc);
        wr_t e;
        e.is_i = 1'b0; e.ia = 8'd0; e.sec = 4'((lin / 16) % 16); e.da = 4'(lin % 16); e.d = d;
        e.cyc = acc + 1;
        sb.push_back(e);
    endtask

    task automatic end_check(input string nm);
        check({nm, "_err"}, 32'(err), 32'(m_err));
        check({nm, "_run"}, 32'(core_run), 32'(m_run));
        check({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_outs"}, {imem_we, dmem_we, core_run, busy, err, dmem_sector, dmem_addr, imem_addr}, 32'd0);
        check({nm, "_wdata"}, {imem_wdata, dmem_wdata}, 32'd0);
    endtask

    task automatic send_cksum(input logic [15:0] sum, input bit bad, input int gap);
`ifdef LOADER_CHECKSUM_EN
        int acc;
        send(bad ? sum + 16'd1 : sum, gap, acc);
        if (bad) m_err = 1'b1;
`endif
    endtask

    task automatic pkt_instr(input int n, input int start, input bit bad);
        int acc;
        logic [15:0] w;
        logic [15:0] sum;
        logic [3:0] junk;
        sum = 16'd0;
        junk = 4'($urandom);
        send({4'h1, junk, 8'(n)}, $urandom_range(0, 2), acc);
        m_err = 1'b0;
        if (n > 0) begin
            w = 16'($urandom);
            w[7:0] = 8'(start);
            send(w, $urandom_range(0, 2), acc);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                send(w, $urandom_range(0, 2), acc);
                push_i(start + i, w, acc);
                sum = sum + w;
            end
            send_cksum(sum, bad, $urandom_range(0, 2));
        end
        end_check("instr");
    endtask

    task automatic pkt_data(input int n, input int sec, input bit bad);
        int acc;
        logic [15:0] w;
        logic [15:0] sum;
        sum = 16'd0;
        send({4'h2, 4'(sec), 8'(n)}, $urandom_range(0, 2), acc);
        m_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            send(w, $urandom_range(0, 2), acc);
            push_d(sec * 16 + i, w, acc);
            sum = sum + w;
        end
        if (n > 0) send_cksum(sum, bad, $urandom_range(0, 2));
        end_check("data");
    endtask

    task automatic pkt_run(input int k);
        int acc;
        logic [15:0] w;
        send(16'h3000, $urandom_range(0, 2), acc);
        m_err = 1'b0;
        m_run = 1'b1;
        check("run_rise", 32'(core_run), 32'd1);
        for (int i = 0; i < k; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'h4) w[15:12] = 4'h5;
            send(w, $urandom_range(0, 2), acc);
            m_err = 1'b1;
            check("run_junk_err", 32'(err), 32'd1);
        end
        send(16'h4000, $urandom_range(0, 2), acc);
        m_err = 1'b0;
        m_run = 1'b0;
        end_check("halt");
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset_n) begin
            if (imem_we && dmem_we) check("we_exclusive", 32'd1, 32'd0);
            if (imem_we || dmem_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {imem_we, dmem_we, 16'd0}, 32'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_port", 32'(imem_we), 32'(e.is_i));
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_i) begin
                        check("imem_addr", 32'(imem_addr), 32'(e.ia));
                        check("imem_wdata", 32'(imem_wdata), 32'(e.d));
                    end else begin
                        check("dmem_loc", {dmem_sector, dmem_addr}, {e.sec, e.da});
                        check("dmem_wdata", 32'(dmem_wdata), 32'(e.d));
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        logic [15:0] sum;
        logic [15:0] w;
        logic [15:0] tw [3];
        int r;
        int c;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'd0;
        m_err = 1'b0;
        m_run = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        check("in_ready", 32'(in_ready), 32'd1);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        // LOAD_INSTR back to back
        tw[0] = 16'hA111; tw[1] = 16'hB222; tw[2] = 16'hC333;
        sum = 16'd0;
        send(16'h1003, 0, acc);
        send(16'h0010, 0, acc);
        for (int i = 0; i < 3; i++) begin
            send(tw[i], 0, acc);
            push_i(16 + i, tw[i], acc);
            sum = sum + tw[i];
        end
        send_cksum(sum, 1'b0, 0);
        end_check("t1");

        // LOAD_DATA across the sector 15 -> 0 wrap
        sum = 16'd0;
        send(16'h2F12, 0, acc);
        for (int i = 0; i < 18; i++) begin
            w = 16'(i);
            send(w, 0, acc);
            push_d(240 + i, w, acc);
            sum = sum + w;
        end
        send_cksum(sum, 1'b0, 0);
        end_check("t2");

        // RUN, junk, HALT
        check("run_pre", 32'(core_run), 32'd0);
        send(16'h3000, 0, acc);
        m_run = 1'b1;
        check("t3_run", 32'(core_run), 32'd1);
        send(16'h1001, 0, acc);
        m_err = 1'b1;
        check("t3_junk_err", 32'(err), 32'd1);
        check("t3_junk_run", 32'(core_run), 32'd1);
        send(16'h4000, 0, acc);
        m_run = 1'b0;
        m_err = 1'b0;
        end_check("t3");

        // illegal command, then gapped LOAD_DATA
        send(16'h7000, 0, acc);
        m_err = 1'b1;
        end_check("t4_illegal");
        send(16'h2202, 0, acc);
        m_err = 1'b0;
        @(negedge clock);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_err_clr", 32'(err), 32'd0);
        sum = 16'd0;
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            send(w, 3, acc);
            push_d(32 + i, w, acc);
            sum = sum + w;
        end
        send_cksum(sum, 1'b0, 0);
        end_check("t4");

        // reset in the middle of an instruction load
        send(16'h1004, 0, acc);
        send(16'h0020, 0, acc);
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            send(w, 0, acc);
            push_i(32 + i, w, acc);
        end
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1 check_all_zero("t5_rst");
        for (int i = 0; i < 2; i++) begin
            in_data = 16'($urandom);
            in_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check_all_zero("t5_hold");
        m_err = 1'b0;
        m_run = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        pkt_data(3, 5, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // checksum good and bad
        for (int k = 0; k < 2; k++) begin
            send(16'h1002, 0, acc);
            send(16'h0000, 0, acc);
            send(16'h0001, 0, acc);
            push_i(0, 16'h0001, acc);
            send(16'hFFFF, 0, acc);
            push_i(1, 16'hFFFF, acc);
            send(k == 0 ? 16'h0000 : 16'h0001, 0, acc);
            m_err = (k == 1);
            end_check(k == 0 ? "ck_good" : "ck_bad");
        end
`endif

        // random packets
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1: pkt_instr($urandom_range(0, 12), $urandom_range(200, 255), ($urandom_range(0, 3) == 0));
                2, 3: pkt_data($urandom_range(0, 20), $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
                4: pkt_run($urandom_range(0, 2));
                default: begin
                    c = $urandom_range(4, 16);
                    w = 16'($urandom);
                    if (c == 16) c = 0;
                    w[15:12] = 4'(c);
                    send(w, $urandom_range(0, 2), acc);
                    if (c != 4) m_err = 1'b1;
                    end_check(c == 4 ? "halt_idle" : "illegal");
                end
            endcase
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check("drain_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
